// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline widths, decoder control bundle and constants
package riscv_pipe_pkg;
  localparam int ALU_OP_W = 3;
  localparam int REG_AW = 5;
  localparam int XLEN = 64;
  typedef struct packed {
    logic alusrc;
    logic memtoreg;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
    logic [ALU_OP_W-1:0] aluop;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/load_use_hazard.sv
// load_use_hazard: flags an ID instruction reading the destination of a load sitting in EX
module load_use_hazard import riscv_pipe_pkg::*; #(
  parameter int REG_AW = riscv_pipe_pkg::REG_AW
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  ctrl_t             id_ctrl,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  ctrl_t             ex_ctrl,
  output logic              hz
);
  logic uses_rs1, uses_rs2, unused;
  assign uses_rs1 = id_valid & (id_ctrl.regwrite | id_ctrl.memwrite | id_ctrl.branch);
  assign uses_rs2 = id_valid & (~id_ctrl.alusrc | id_ctrl.memwrite | id_ctrl.branch);
  assign hz = ex_valid & ex_ctrl.memread & (ex_rd != '0) &
              ((uses_rs1 & (id_rs1 == ex_rd)) | (uses_rs2 & (id_rs2 == ex_rd)));
  assign unused = ^{id_ctrl, ex_ctrl};
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion, flush and stall counter
module id_ex_stage import riscv_pipe_pkg::*; #(
  parameter int XLEN = riscv_pipe_pkg::XLEN,
  parameter int REG_AW = riscv_pipe_pkg::REG_AW,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7b5,
  input  ctrl_t             id_ctrl,
  input  logic              flush,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7b5,
  output ctrl_t             ex_ctrl,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic              funct7b5;
    ctrl_t             ctrl;
  } ex_t;
  ex_t ex_q, ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic hz;
  load_use_hazard #(.REG_AW(REG_AW)) u_hz (
    .id_valid(id_valid),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_ctrl(id_ctrl),
    .ex_valid(ex_q.valid),
    .ex_rd(ex_q.rd),
    .ex_ctrl(ex_q.ctrl),
    .hz(hz)
  );
  assign stall = hz & ~flush;
  always_comb begin
    ex_d = (flush | stall) ? ex_t'('0) : ex_t'{
      valid: id_valid, pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data,
      imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd, funct3: id_funct3,
      funct7b5: id_funct7b5, ctrl: id_valid ? id_ctrl : CTRL_NOP};
    stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign ex_valid = ex_q.valid;
  assign ex_pc = ex_q.pc;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm = ex_q.imm;
  assign ex_rs1 = ex_q.rs1;
  assign ex_rs2 = ex_q.rs2;
  assign ex_rd = ex_q.rd;
  assign ex_funct3 = ex_q.funct3;
  assign ex_funct7b5 = ex_q.funct7b5;
  assign ex_ctrl = ex_q.ctrl;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
  import riscv_pipe_pkg::*;
  localparam ctrl_t R_CTRL = 9'b001000010;
  localparam ctrl_t LD_CTRL = 9'b111100000;
  localparam ctrl_t ADDI_CTRL = 9'b101000011;
  localparam ctrl_t SD_CTRL = 9'b100010000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0;
  logic [63:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [2:0] id_funct3 = '0;
  logic id_funct7b5 = 1'b0;
  ctrl_t id_ctrl = '0;
  logic flush = 1'b0;
  logic ex_valid, ex_funct7b5, stall;
  logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  ctrl_t ex_ctrl;
  logic [3:0] stall_cnt;
  int errors = 0;
  int checks = 0;
  logic [3:0] exp_cnt = '0;
  id_ex_stage #(.XLEN(64), .REG_AW(5), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_ctrl(id_ctrl), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_ctrl(ex_ctrl), .stall(stall), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic set_id(input logic v, input ctrl_t c, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    id_valid = v;
    id_ctrl = c;
    id_rs1 = r1;
    id_rs2 = r2;
    id_rd = rd;
    id_pc = {$urandom, $urandom};
    id_rs1_data = {$urandom, $urandom};
    id_rs2_data = {$urandom, $urandom};
    id_imm = {$urandom, $urandom};
    id_funct3 = 3'($urandom);
    id_funct7b5 = 1'($urandom);
  endtask
  task automatic load_into_ex(input logic [4:0] rd);
    @(negedge clk);
    set_id(1'b1, LD_CTRL, 5'd1, 5'd2, rd);
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      set_id(1'($urandom), ctrl_t'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      flush = 1'($urandom);
    end
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ex_valid); end
    checks++; if (ex_ctrl !== 9'd0 || ex_pc !== 64'd0 || ex_rd !== 5'd0 || ex_imm !== 64'd0)
      begin errors++; $display("FAIL reset_fields ctrl=%b pc=%h rd=%0d imm=%h exp=0", ex_ctrl, ex_pc, ex_rd, ex_imm); end
    checks++; if (stall !== 1'b0 || stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall stall=%b cnt=%0d exp=0,0", stall, stall_cnt); end
    @(negedge clk);
    flush = 1'b0;
    rst_n = 1'b1;
    set_id(1'b1, R_CTRL, 5'd3, 5'd4, 5'd5);
    @(posedge clk);
    #1;
    checks++; if (ex_ctrl !== R_CTRL || ex_rd !== 5'd5 || ex_valid !== 1'b1)
      begin errors++; $display("FAIL first_rtype ctrl=%b rd=%0d v=%b exp=%b,5,1", ex_ctrl, ex_rd, ex_valid, R_CTRL); end
    checks++; if (ex_pc !== id_pc || ex_rs1_data !== id_rs1_data || ex_rs2_data !== id_rs2_data || ex_imm !== id_imm || ex_funct3 !== id_funct3 || ex_funct7b5 !== id_funct7b5 || ex_rs1 !== 5'd3 || ex_rs2 !== 5'd4)
      begin errors++; $display("FAIL first_payload pc=%h exp=%h imm=%h exp=%h", ex_pc, id_pc, ex_imm, id_imm); end
  endtask
  task automatic test_load_use;
    load_into_ex(5'd5);
    @(negedge clk);
    set_id(1'b1, R_CTRL, 5'd5, 5'd7, 5'd6);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", stall); end
    @(posedge clk);
    #1;
    exp_cnt = 4'd1;
    checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 9'd0 || stall_cnt !== exp_cnt)
      begin errors++; $display("FAIL lu_bubble v=%b ctrl=%b cnt=%0d exp=0,0,%0d", ex_valid, ex_ctrl, stall_cnt, exp_cnt); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got=%b exp=0", stall); end
    @(posedge clk);
    #1;
    checks++; if (ex_valid !== 1'b1 || ex_ctrl !== R_CTRL || ex_rd !== 5'd6 || ex_rs1 !== 5'd5 || stall_cnt !== exp_cnt)
      begin errors++; $display("FAIL lu_add_enters v=%b ctrl=%b rd=%0d cnt=%0d exp=1,%b,6,%0d", ex_valid, ex_ctrl, ex_rd, stall_cnt, R_CTRL, exp_cnt); end
  endtask
  task automatic test_non_hazard;
    load_into_ex(5'd0);
    @(negedge clk);
    set_id(1'b1, R_CTRL, 5'd0, 5'd0, 5'd6);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ld_x0 got=%b exp=0", stall); end
    load_into_ex(5'd5);
    @(negedge clk);
    set_id(1'b1, ADDI_CTRL, 5'd7, 5'd5, 5'd6);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL addi_rs2_field got=%b exp=0", stall); end
    load_into_ex(5'd5);
    @(negedge clk);
    set_id(1'b1, SD_CTRL, 5'd6, 5'd5, 5'd0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sd_rs2 got=%b exp=1", stall); end
    @(posedge clk);
    #1;
    exp_cnt = 4'd2;
    checks++; if (ex_valid !== 1'b0 || stall_cnt !== exp_cnt)
      begin errors++; $display("FAIL sd_bubble v=%b cnt=%0d exp=0,%0d", ex_valid, stall_cnt, exp_cnt); end
  endtask
  task automatic test_flush;
    load_into_ex(5'd5);
    @(negedge clk);
    set_id(1'b1, R_CTRL, 5'd5, 5'd5, 5'd9);
    flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_prio_stall got=%b exp=0", stall); end
    @(posedge clk);
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 9'd0 || ex_pc !== 64'd0 || stall_cnt !== exp_cnt)
      begin errors++; $display("FAIL flush_prio_bubble v=%b ctrl=%b pc=%h cnt=%0d exp=0,0,0,%0d", ex_valid, ex_ctrl, ex_pc, stall_cnt, exp_cnt); end
    @(negedge clk);
    set_id(1'b1, R_CTRL, 5'd1, 5'd2, 5'd3);
    @(posedge clk);
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0) begin errors++; $display("FAIL flush_alone v=%b rd=%0d exp=0,0", ex_valid, ex_rd); end
    @(negedge clk);
    flush = 1'b0;
  endtask
  task automatic test_saturation;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    exp_cnt = 4'd0;
    for (int i = 1; i <= 16; i++) begin
      load_into_ex(5'd7);
      @(negedge clk);
      set_id(1'b1, R_CTRL, 5'd7, 5'd1, 5'd8);
      @(posedge clk);
      #1;
      if (i == 15) begin
        checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_15 got=%h exp=F", stall_cnt); end
      end
    end
    checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_16 got=%h exp=F", stall_cnt); end
  endtask
  task automatic test_invalid_and_async;
    @(negedge clk);
    set_id(1'b0, R_CTRL, 5'd1, 5'd2, 5'd3);
    @(posedge clk);
    #1;
    checks++; if (ex_ctrl !== 9'd0 || ex_valid !== 1'b0) begin errors++; $display("FAIL invalid_slot ctrl=%b v=%b exp=0,0", ex_ctrl, ex_valid); end
    load_into_ex(5'd5);
    @(negedge clk);
    set_id(1'b1, R_CTRL, 5'd5, 5'd6, 5'd4);
    #1;
    checks++; if (stall !== 1'b1 || ex_valid !== 1'b1) begin errors++; $display("FAIL pre_async stall=%b v=%b exp=1,1", stall, ex_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 9'd0 || ex_rd !== 5'd0 || stall !== 1'b0 || stall_cnt !== 4'd0)
      begin errors++; $display("FAIL async_reset v=%b ctrl=%b rd=%0d stall=%b cnt=%0d exp=all 0", ex_valid, ex_ctrl, ex_rd, stall, stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_non_hazard();
    test_flush();
    test_saturation();
    test_invalid_and_async();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
